// File: rtl/cpx_src_tx_pkg.sv
// Shared constants and packet entry layout for the CPX source-side transmitter.
package cpx_src_tx_pkg;

   localparam int CPX_WIDTH   = 145;
   localparam int CPX_NDEST   = 8;
   localparam int CPX_DEST_W  = 3;
   localparam int CPX_CREDITS = 2;

   // One FIFO entry: dest in the top bits, then the atomic flag, payload at the bottom.
   typedef struct packed {
      logic [CPX_DEST_W-1:0] dest;
      logic                  atom;
      logic [CPX_WIDTH-1:0]  data;
   } cpx_entry_t;

   function automatic logic [CPX_NDEST-1:0] dest_onehot(input logic [CPX_DEST_W-1:0] dest);
      logic [CPX_NDEST-1:0] oh;
      oh       = '0;
      oh[dest] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/cpx_src_credit.sv
// Per-destination crossbar queue credit counter; flags a grant that would overflow it.
module cpx_src_credit #(
   parameter  int CREDITS = 2,
   localparam int CW      = $clog2(CREDITS + 1)
) (
   input  logic          rclk,
   input  logic          arst_l,
   input  logic          req,
   input  logic          grant,
   output logic [CW-1:0] credit,
   output logic          home,
   output logic          err
);

   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

   logic [CW-1:0] credit_q;
   logic [CW-1:0] credit_d;
   logic          err_s;

   // Next credit value: request consumes, grant returns, both together cancel.
   always_comb begin
      credit_d = credit_q;
      err_s    = 1'b0;
      case ({req, grant})
         2'b10: begin
            if (credit_q != '0) begin
               credit_d = credit_q - CW'(1);
            end else begin
               credit_d = credit_q;
            end
         end
         2'b01: begin
            if (credit_q == CRED_MAX) begin
               credit_d = credit_q;
               err_s    = 1'b1;
            end else begin
               credit_d = credit_q + CW'(1);
            end
         end
         default: credit_d = credit_q;
      endcase
   end

   // Credit register.
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         credit_q <= CRED_MAX;
      end else begin
         credit_q <= credit_d;
      end
   end

   assign credit = credit_q;
   assign home   = (credit_q == CRED_MAX);
   assign err    = err_s;

endmodule

// File: rtl/cpx_src_tx.sv
// CPX source transmitter: packet FIFO, credit-gated request in cq, payload in ca.
// Optional stall counter port enabled by CPX_SRC_TX_STALL_CNT_EN.
module cpx_src_tx
   import cpx_src_tx_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int NDEST   = CPX_NDEST,
   parameter int DWIDTH  = CPX_WIDTH,
   parameter int CREDITS = CPX_CREDITS
) (
   input  logic              rclk,
   input  logic              arst_l,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [2:0]        in_dest,
   input  logic              in_atom,
   input  logic [DWIDTH-1:0] in_data,
   input  logic [NDEST-1:0]  cpx_grant_cx,
   output logic [NDEST-1:0]  cpx_req_cq,
   output logic              cpx_atom_cq,
   output logic [DWIDTH-1:0] cpx_data_ca,
   output logic              tx_idle,
   output logic              tx_err
`ifdef CPX_SRC_TX_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int              AW       = $clog2(DEPTH);
   localparam int              CW       = $clog2(CREDITS + 1);
   localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]     PAIR_CNT = (AW + 1)'(2);
   localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);

   cpx_entry_t              mem_q [DEPTH];
   cpx_entry_t              mem_d [DEPTH];
   cpx_entry_t              head_s;
   cpx_entry_t              in_ent_s;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [AW:0]             cnt_q, cnt_d;
   logic                    atom2_q, atom2_d;
   logic [DWIDTH-1:0]       data_ca_q, data_ca_d;
   logic                    data_vld_q, data_vld_d;
   logic                    tx_err_q, tx_err_d;
   logic                    push_s, issue_s, atom_issue_s, stall_s;
   logic                    empty_s, full_s;
   logic [CW-1:0]           head_cred_s;
   logic [NDEST-1:0]        req_s, cred_err_s, cred_home_s;
   logic [NDEST-1:0][CW-1:0] credit_s;

   assign head_s      = mem_q[rd_ptr_q];
   assign empty_s     = (cnt_q == '0);
   assign full_s      = (cnt_q == FULL_CNT);
   assign head_cred_s = credit_s[head_s.dest];
   assign push_s      = in_vld & in_rdy;

   // Pack the incoming packet into a FIFO entry.
   always_comb begin
      in_ent_s      = '0;
      in_ent_s.dest = in_dest;
      in_ent_s.atom = in_atom;
      in_ent_s.data = in_data;
   end

   // Issue decision for the head entry. An atomic head needs the whole queue
   // free and its partner already buffered so the two halves go out back to back;
   // each half is a normal request and consumes one of the reserved credits.
   always_comb begin
      issue_s      = 1'b0;
      atom_issue_s = 1'b0;
      stall_s      = 1'b0;
      if (empty_s) begin
         issue_s = 1'b0;
      end else if (atom2_q) begin
         issue_s = 1'b1;
      end else if (head_s.atom) begin
         if (head_cred_s != CRED_MAX) begin
            stall_s = 1'b1;
         end else if (cnt_q >= PAIR_CNT) begin
            issue_s      = 1'b1;
            atom_issue_s = 1'b1;
         end else begin
            issue_s = 1'b0;
         end
      end else if (head_cred_s != '0) begin
         issue_s = 1'b1;
      end else begin
         stall_s = 1'b1;
      end
   end

   // Request vector and ca-stage payload.
   always_comb begin
      req_s      = '0;
      data_ca_d  = '0;
      data_vld_d = issue_s;
      atom2_d    = atom_issue_s;
      if (issue_s) begin
         req_s     = NDEST'(dest_onehot(head_s.dest));
         data_ca_d = head_s.data;
      end else begin
         req_s     = '0;
         data_ca_d = '0;
      end
   end

   // FIFO pointers, occupancy and storage.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = in_ent_s;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (issue_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, issue_s})
         2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
         2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   assign tx_err_d = tx_err_q | (|cred_err_s);

   // Datapath and control state.
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         atom2_q    <= 1'b0;
         data_ca_q  <= '0;
         data_vld_q <= 1'b0;
         tx_err_q   <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         atom2_q    <= atom2_d;
         data_ca_q  <= data_ca_d;
         data_vld_q <= data_vld_d;
         tx_err_q   <= tx_err_d;
      end
   end

   for (genvar g = 0; g < NDEST; g++) begin : g_cred
      cpx_src_credit #(
         .CREDITS (CREDITS)
      ) u_cred (
         .rclk   (rclk),
         .arst_l (arst_l),
         .req    (req_s[g]),
         .grant  (cpx_grant_cx[g]),
         .credit (credit_s[g]),
         .home   (cred_home_s[g]),
         .err    (cred_err_s[g])
      );
   end

`ifdef CPX_SRC_TX_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of credit-blocked cycles.
   always_comb begin
      if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   logic unused_stall_s;
   assign unused_stall_s = stall_s;
`endif

   assign in_rdy      = ~full_s | issue_s;
   assign cpx_req_cq  = req_s;
   assign cpx_atom_cq = atom_issue_s;
   assign cpx_data_ca = data_ca_q;
   assign tx_idle     = empty_s & ~data_vld_q & (&cred_home_s);
   assign tx_err      = tx_err_q;

endmodule

// File: tb/tb_cpx_src_tx.sv
// Directed table-driven bench for cpx_src_tx plus hand sequences for atomic, full-FIFO and reset cases.
module tb_cpx_src_tx;

   logic         rclk;
   logic         arst_l;
   logic         in_vld;
   logic         in_rdy;
   logic [2:0]   in_dest;
   logic         in_atom;
   logic [144:0] in_data;
   logic [7:0]   cpx_grant_cx;
   logic [7:0]   cpx_req_cq;
   logic         cpx_atom_cq;
   logic [144:0] cpx_data_ca;
   logic         tx_idle;
   logic         tx_err;
`ifdef CPX_SRC_TX_STALL_CNT_EN
   logic [15:0]  stall_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   cpx_src_tx dut (
      .rclk         (rclk),
      .arst_l       (arst_l),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .in_dest      (in_dest),
      .in_atom      (in_atom),
      .in_data      (in_data),
      .cpx_grant_cx (cpx_grant_cx),
      .cpx_req_cq   (cpx_req_cq),
      .cpx_atom_cq  (cpx_atom_cq),
      .cpx_data_ca  (cpx_data_ca),
      .tx_idle      (tx_idle),
      .tx_err       (tx_err)
`ifdef CPX_SRC_TX_STALL_CNT_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic         vld;
      logic [2:0]   dest;
      logic [144:0] data;
      logic [7:0]   grant;
      logic [7:0]   exp_req;
      logic [144:0] exp_data;
      logic         exp_idle;
      logic         exp_err;
      logic [2:0]   cdest;
      logic [1:0]   ccred;
   } vec_t;

   vec_t tbl[$];
   logic [144:0] exp_q[$];

   function automatic vec_t v(input logic vld, input logic [2:0] dest, input logic [144:0] data,
                              input logic [7:0] grant, input logic [7:0] er, input logic [144:0] ed,
                              input logic ei, input logic ee, input logic [2:0] cd, input logic [1:0] cc);
      vec_t r;
      r.vld = vld; r.dest = dest; r.data = data; r.grant = grant;
      r.exp_req = er; r.exp_data = ed; r.exp_idle = ei; r.exp_err = ee;
      r.cdest = cd; r.ccred = cc;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge rclk);
      #1;
   endtask

   task automatic drive(input logic vl, input logic [2:0] d, input logic a,
                        input logic [144:0] dat, input logic [7:0] g);
      in_vld = vl; in_dest = d; in_atom = a; in_data = dat; cpx_grant_cx = g;
   endtask

   task automatic chk_cred(input string nm, input logic [2:0] d, input logic [1:0] exp);
      chk(nm, 160'(dut.credit_s[d]), 160'(exp));
   endtask

   initial begin
      int guard;
      arst_l = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 145'h0, 8'h00);

      // vld dest data grant | req data idle err | credit dest/value
      tbl.push_back(v(1'b1, 3'd3, 145'h12345, 8'h00, 8'h00, 145'h0,     1'b1, 1'b0, 3'd3, 2'd2));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h08, 145'h0,     1'b0, 1'b0, 3'd3, 2'd2));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'h12345, 1'b0, 1'b0, 3'd3, 2'd1));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h08, 8'h00, 145'h0,     1'b0, 1'b0, 3'd3, 2'd1));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'h0,     1'b1, 1'b0, 3'd3, 2'd2));
      tbl.push_back(v(1'b1, 3'd5, 145'hA1,    8'h00, 8'h00, 145'h0,     1'b1, 1'b0, 3'd5, 2'd2));
      tbl.push_back(v(1'b1, 3'd5, 145'hA2,    8'h00, 8'h20, 145'h0,     1'b0, 1'b0, 3'd5, 2'd2));
      tbl.push_back(v(1'b1, 3'd5, 145'hA3,    8'h00, 8'h20, 145'hA1,    1'b0, 1'b0, 3'd5, 2'd1));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'hA2,    1'b0, 1'b0, 3'd5, 2'd0));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'h0,     1'b0, 1'b0, 3'd5, 2'd0));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h20, 8'h00, 145'h0,     1'b0, 1'b0, 3'd5, 2'd0));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h20, 145'h0,     1'b0, 1'b0, 3'd5, 2'd1));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'hA3,    1'b0, 1'b0, 3'd5, 2'd0));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h20, 8'h00, 145'h0,     1'b0, 1'b0, 3'd5, 2'd0));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h20, 8'h00, 145'h0,     1'b0, 1'b0, 3'd5, 2'd1));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'h0,     1'b1, 1'b0, 3'd5, 2'd2));
      tbl.push_back(v(1'b1, 3'd2, 145'h22,    8'h00, 8'h00, 145'h0,     1'b1, 1'b0, 3'd2, 2'd2));
      tbl.push_back(v(1'b1, 3'd2, 145'h23,    8'h00, 8'h04, 145'h0,     1'b0, 1'b0, 3'd2, 2'd2));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h04, 8'h04, 145'h22,    1'b0, 1'b0, 3'd2, 2'd1));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'h23,    1'b0, 1'b0, 3'd2, 2'd1));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h04, 8'h00, 145'h0,     1'b0, 1'b0, 3'd2, 2'd1));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'h0,     1'b1, 1'b0, 3'd2, 2'd2));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h80, 8'h00, 145'h0,     1'b1, 1'b0, 3'd7, 2'd2));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'h0,     1'b1, 1'b1, 3'd7, 2'd2));
      tbl.push_back(v(1'b0, 3'd0, 145'h0,     8'h00, 8'h00, 145'h0,     1'b1, 1'b1, 3'd7, 2'd2));

      // Reset values while reset is held.
      #12;
      chk("rst req",  160'(cpx_req_cq),  160'(8'h00));
      chk("rst atom", 160'(cpx_atom_cq), 160'(1'b0));
      chk("rst data", 160'(cpx_data_ca), 160'(145'h0));
      chk("rst rdy",  160'(in_rdy),      160'(1'b1));
      chk("rst idle", 160'(tx_idle),     160'(1'b1));
      chk("rst err",  160'(tx_err),      160'(1'b0));
      chk_cred("rst cred4", 3'd4, 2'd2);
`ifdef CPX_SRC_TX_STALL_CNT_EN
      chk("rst stall", 160'(stall_cnt), 160'(16'd0));
`endif
      #5 arst_l = 1'b1;
      step();

      foreach (tbl[i]) begin
         drive(tbl[i].vld, tbl[i].dest, 1'b0, tbl[i].data, tbl[i].grant);
         chk($sformatf("r%0d req", i),  160'(cpx_req_cq),  160'(tbl[i].exp_req));
         chk($sformatf("r%0d atom", i), 160'(cpx_atom_cq), 160'(1'b0));
         chk($sformatf("r%0d data", i), 160'(cpx_data_ca), 160'(tbl[i].exp_data));
         chk($sformatf("r%0d rdy", i),  160'(in_rdy),      160'(1'b1));
         chk($sformatf("r%0d idle", i), 160'(tx_idle),     160'(tbl[i].exp_idle));
         chk($sformatf("r%0d err", i),  160'(tx_err),      160'(tbl[i].exp_err));
         chk_cred($sformatf("r%0d cred", i), tbl[i].cdest, tbl[i].ccred);
         step();
      end
      drive(1'b0, 3'd0, 1'b0, 145'h0, 8'h00);
`ifdef CPX_SRC_TX_STALL_CNT_EN
      chk("stall after table", 160'(stall_cnt), 160'(16'd3));
`endif

      // Atomic pair to dest 0 while credit[0] is 1.
      drive(1'b1, 3'd0, 1'b0, 145'h30, 8'h00); step();
      drive(1'b1, 3'd0, 1'b1, 145'h31, 8'h00);
      chk("at plain req", 160'(cpx_req_cq), 160'(8'h01));
      step();
      drive(1'b1, 3'd0, 1'b0, 145'h32, 8'h00);
      chk("at wait1 req", 160'(cpx_req_cq), 160'(8'h00));
      chk("at plain data", 160'(cpx_data_ca), 160'(145'h30));
      step();
      drive(1'b0, 3'd0, 1'b0, 145'h0, 8'h01);
      chk("at wait2 req", 160'(cpx_req_cq), 160'(8'h00));
      chk_cred("at cred1", 3'd0, 2'd1);
      step();
      drive(1'b0, 3'd0, 1'b0, 145'h0, 8'h00);
      chk("at first req", 160'(cpx_req_cq), 160'(8'h01));
      chk("at first atom", 160'(cpx_atom_cq), 160'(1'b1));
      step();
      chk("at second req", 160'(cpx_req_cq), 160'(8'h01));
      chk("at second atom", 160'(cpx_atom_cq), 160'(1'b0));
      chk("at first data", 160'(cpx_data_ca), 160'(145'h31));
      step();
      chk("at after req", 160'(cpx_req_cq), 160'(8'h00));
      chk("at second data", 160'(cpx_data_ca), 160'(145'h32));
      cpx_grant_cx = 8'h01; step();
      step();
      cpx_grant_cx = 8'h00;
      chk_cred("at cred home", 3'd0, 2'd2);
      chk("at idle", 160'(tx_idle), 160'(1'b1));

      // Fill the FIFO behind a credit-starved head on dest 6, then drain across the wrap.
      drive(1'b1, 3'd6, 1'b0, 145'h60, 8'h00); step();
      drive(1'b1, 3'd6, 1'b0, 145'h61, 8'h00);
      chk("ff req p0", 160'(cpx_req_cq), 160'(8'h40)); step();
      drive(1'b1, 3'd6, 1'b0, 145'h62, 8'h00);
      chk("ff req p1", 160'(cpx_req_cq), 160'(8'h40)); step();
      drive(1'b1, 3'd6, 1'b0, 145'h63, 8'h00);
      chk("ff blocked", 160'(cpx_req_cq), 160'(8'h00)); step();
      drive(1'b1, 3'd6, 1'b0, 145'h64, 8'h00); step();
      drive(1'b1, 3'd6, 1'b0, 145'h65, 8'h00);
      chk("ff rdy 3", 160'(in_rdy), 160'(1'b1)); step();
      drive(1'b1, 3'd6, 1'b0, 145'h66, 8'h00);
      chk("ff full rdy", 160'(in_rdy), 160'(1'b0));
      chk("ff full req", 160'(cpx_req_cq), 160'(8'h00)); step();
      drive(1'b1, 3'd6, 1'b0, 145'h66, 8'h40);
      chk("ff full rdy2", 160'(in_rdy), 160'(1'b0)); step();
      drive(1'b1, 3'd6, 1'b0, 145'h66, 8'h00);
      chk("ff pop req", 160'(cpx_req_cq), 160'(8'h40));
      chk("ff pop rdy", 160'(in_rdy), 160'(1'b1)); step();
      drive(1'b0, 3'd0, 1'b0, 145'h0, 8'h00);
      exp_q = '{145'h62, 145'h63, 145'h64, 145'h65, 145'h66};
      guard = 0;
      while (exp_q.size() != 0 && guard < 30) begin
         cpx_grant_cx = 8'h40;
         if (cpx_data_ca != '0) begin
            chk("ff drain order", 160'(cpx_data_ca), 160'(exp_q.pop_front()));
         end
         step();
         guard++;
      end
      cpx_grant_cx = 8'h00;
      chk("ff drain left", 160'(exp_q.size()), 160'(0));
      chk("ff idle", 160'(tx_idle), 160'(1'b1));

      // Asynchronous reset with packets queued, data in ca and an atomic pending.
      drive(1'b1, 3'd1, 1'b0, 145'h70, 8'h00); step();
      drive(1'b1, 3'd1, 1'b0, 145'h71, 8'h00); step();
      drive(1'b1, 3'd1, 1'b1, 145'h72, 8'h00); step();
      drive(1'b1, 3'd1, 1'b0, 145'h73, 8'h00);
      chk("pre-rst data", 160'(cpx_data_ca), 160'(145'h71));
      chk("pre-rst err", 160'(tx_err), 160'(1'b1));
      #2 arst_l = 1'b0;
      #1;
      chk("arst req",  160'(cpx_req_cq),  160'(8'h00));
      chk("arst atom", 160'(cpx_atom_cq), 160'(1'b0));
      chk("arst data", 160'(cpx_data_ca), 160'(145'h0));
      chk("arst rdy",  160'(in_rdy),      160'(1'b1));
      chk("arst idle", 160'(tx_idle),     160'(1'b1));
      chk("arst err",  160'(tx_err),      160'(1'b0));
      chk_cred("arst cred1", 3'd1, 2'd2);
`ifdef CPX_SRC_TX_STALL_CNT_EN
      chk("arst stall", 160'(stall_cnt), 160'(16'd0));
`endif
      drive(1'b0, 3'd0, 1'b0, 145'h0, 8'h00);
      #3 arst_l = 1'b1;
      step();
      chk("post-rst req",  160'(cpx_req_cq), 160'(8'h00));
      chk("post-rst idle", 160'(tx_idle),    160'(1'b1));
      step();
      chk("post-rst data", 160'(cpx_data_ca), 160'(145'h0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
